// File: rtl/chaos_seq_gen.sv
// chaos_seq_gen: five fixed-point logistic maps x' = r*x*(1-x) sharing one
// 32x32 multiplier. Runs a warm-up transient after start, then hands out one
// 5-word sample per rand_vld/rand_rdy handshake.

// One map state register: loaded from its seed (0 replaced by 1) or
// overwritten with the freshly computed iterate.
module chaos_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_seed,
  input  logic [W-1:0] seed,
  input  logic         wr,
  input  logic [W-1:0] y,
  output logic [W-1:0] x
);
  logic [W-1:0] x_d, x_q;

  // next map value: seed on start, new iterate on write, else hold
  always_comb begin
    x_d = x_q;
    if (ld_seed)  x_d = (seed == '0) ? W'(1) : seed;
    else if (wr)  x_d = y;
  end

  // map state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) x_q <= '0;
    else        x_q <= x_d;
  end

  assign x = x_q;
endmodule

module chaos_seq_gen #(
  parameter int          CHAOS_OVLD_W = 32,            // only 32 is supported
  parameter logic [31:0] R_Q          = 32'hE000_0000, // r in unsigned Q2.30
  parameter int          WARMUP_ITER  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic [5*CHAOS_OVLD_W-1:0] seed,
  output logic [CHAOS_OVLD_W-1:0]   rand_x1,
  output logic [CHAOS_OVLD_W-1:0]   rand_x2,
  output logic [CHAOS_OVLD_W-1:0]   rand_x3,
  output logic [CHAOS_OVLD_W-1:0]   rand_z1,
  output logic [CHAOS_OVLD_W-1:0]   rand_z2,
  output logic                      rand_vld,
  input  logic                      rand_rdy,
  output logic                      busy
);
  localparam int W      = CHAOS_OVLD_W;
  localparam int NUM_CH = 5;
  localparam int IW     = (WARMUP_ITER < 1) ? 1 : $clog2(WARMUP_ITER + 1);

  typedef enum logic [1:0] {IDLE, CALC_P, CALC_R, OUT} state_e;

  state_e                   state_d, state_q;
  logic [2:0]               ch_d, ch_q;
  logic [IW-1:0]            iter_d, iter_q;
  logic [W-1:0]             p_d, p_q;
  logic [NUM_CH-1:0][W-1:0] rand_d, rand_q;
  logic                     vld_d, vld_q;
  logic                     busy_d, busy_q;

  logic [NUM_CH-1:0][W-1:0] x_arr;
  logic [NUM_CH-1:0]        wr_ch;
  logic                     ld_seed;
  logic [W-1:0]             mul_a, mul_b;
  logic [2*W-1:0]           prod;
  logic [W-1:0]             y_raw, y_val;
  logic                     unused_prod;

  // map state lanes
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    chaos_lane #(.W(W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld_seed (ld_seed),
      .seed    (seed[g*W +: W]),
      .wr      (wr_ch[g]),
      .y       (y_val),
      .x       (x_arr[g])
    );
  end

  // shared multiplier operand mux: x*(2^32-x) in CALC_P, p*r in CALC_R
  always_comb begin
    mul_a = x_arr[ch_q];
    mul_b = ~x_arr[ch_q] + W'(1);
    if (state_q == CALC_R) begin
      mul_a = p_q;
      mul_b = R_Q;
    end
  end

  assign prod  = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
  // p <= 2^30 keeps p*r below 2^62, so bits [61:30] never overflow
  assign y_raw = prod[61:30];
  assign y_val = (y_raw == '0) ? W'(1) : y_raw;
  assign unused_prod = ^{prod[29:0]};

  // lane load/write strobes; stop suppresses both
  always_comb begin
    ld_seed = (state_q == IDLE) && start && !stop;
    wr_ch   = '0;
    if (state_q == CALC_R && !stop) wr_ch[ch_q] = 1'b1;
  end

  // sequencer next state: stop first, then per-state behaviour
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    iter_d  = iter_q;
    p_d     = p_q;
    rand_d  = rand_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    if (stop) begin
      state_d = IDLE;
      vld_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = CALC_P;
          ch_d    = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
        end
        CALC_P: begin
          p_d     = prod[2*W-1:W];
          state_d = CALC_R;
        end
        CALC_R: begin
          if (ch_q != 3'(NUM_CH - 1)) begin
            ch_d    = ch_q + 3'd1;
            state_d = CALC_P;
          end else begin
            ch_d = '0;
            // iter counts up from 0 and stops at WARMUP_ITER
            if (iter_q != IW'(WARMUP_ITER)) begin
              iter_d  = iter_q + IW'(1);
              state_d = CALC_P;
            end else begin
              state_d = OUT;
            end
          end
        end
        OUT: begin
          // first OUT cycle always has vld low: present the new sample
          if (!vld_q) begin
            rand_d = x_arr;
            vld_d  = 1'b1;
          end else if (rand_rdy) begin
            // one more iteration, warm-up already satisfied
            vld_d   = 1'b0;
            state_d = CALC_P;
            ch_d    = '0;
            iter_d  = IW'(WARMUP_ITER);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // sequencer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      iter_q  <= '0;
      p_q     <= '0;
      rand_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      iter_q  <= iter_d;
      p_q     <= p_d;
      rand_q  <= rand_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  assign rand_x1  = rand_q[0];
  assign rand_x2  = rand_q[1];
  assign rand_x3  = rand_q[2];
  assign rand_z1  = rand_q[3];
  assign rand_z2  = rand_q[4];
  assign rand_vld = vld_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_chaos_seq_gen.sv
// Directed bench for chaos_seq_gen: three instances (basic r, max r, full
// warm-up) share stimulus; expected samples are queued at start and popped
// when rand_vld is observed.
module tb_chaos_seq_gen;
  typedef logic [4:0][31:0] samp_t;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, rdy = 1'b0;
  samp_t       seed = '0;
  samp_t       r0, r1, r2;
  logic        v0, v1, v2, b0, b1, b2;
  int          nchk = 0, nerr = 0, cyc = 0;
  samp_t       q0[$], q2[$];

  always #5 clk = ~clk;

  chaos_seq_gen #(.R_Q(32'hE000_0000), .WARMUP_ITER(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .seed(seed),
    .rand_x1(r0[0]), .rand_x2(r0[1]), .rand_x3(r0[2]), .rand_z1(r0[3]), .rand_z2(r0[4]),
    .rand_vld(v0), .rand_rdy(rdy), .busy(b0));
  chaos_seq_gen #(.R_Q(32'hFFFF_FFFF), .WARMUP_ITER(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .seed(seed),
    .rand_x1(r1[0]), .rand_x2(r1[1]), .rand_x3(r1[2]), .rand_z1(r1[3]), .rand_z2(r1[4]),
    .rand_vld(v1), .rand_rdy(rdy), .busy(b1));
  chaos_seq_gen #(.R_Q(32'hE000_0000), .WARMUP_ITER(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .seed(seed),
    .rand_x1(r2[0]), .rand_x2(r2[1]), .rand_x3(r2[2]), .rand_z1(r2[3]), .rand_z2(r2[4]),
    .rand_vld(v2), .rand_rdy(rdy), .busy(b2));

  task automatic step();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input samp_t obs, input samp_t exp);
    for (int i = 0; i < 5; i++) chk($sformatf("%s[%0d]", tag, i), obs[i], exp[i]);
  endtask

  // reference logistic map, n full iterations over all five channels
  function automatic samp_t model(input samp_t s, input logic [31:0] r, input int n);
    samp_t x;
    logic [63:0] a;
    logic [31:0] p, y;
    x = s;
    for (int i = 0; i < 5; i++) if (x[i] == 32'h0) x[i] = 32'h1;
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 5; i++) begin
        a = {32'h0, x[i]} * (64'h1_0000_0000 - {32'h0, x[i]});
        p = a[63:32];
        a = {32'h0, p} * {32'h0, r};
        y = a[61:30];
        if (y == 32'h0) y = 32'h1;
        x[i] = y;
      end
    return x;
  endfunction

  function automatic logic vsel(input int d);
    case (d)
      0:       return v0;
      1:       return v1;
      default: return v2;
    endcase
  endfunction

  task automatic wait_v(input int d, input int maxc, output int n);
    n = 0;
    while (vsel(d) !== 1'b1 && n < maxc) begin step(); n++; end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  initial begin
    samp_t sA, sZ, sR, held, prev, ones;
    int n, t0, bad, lows;
    sA   = {5{32'h8000_0000}};
    ones = {5{32'hFFFF_FFFF}};
    sZ   = sA; sZ[0] = 32'h0;
    sR   = {32'h0000_0003, 32'h1234_5678, 32'hDEAD_BEEF, 32'h7654_3210, 32'h0BAD_F00D};

    // reset state
    step();
    chk_s("rst_data", r0, '0);
    chk("rst_vld", 32'(v0), 0);
    chk("rst_busy", 32'(b0), 0);
    rst_n = 1'b1;
    step();

    // basic map, max coefficient, and warm-up latency in parallel
    seed = sA; rdy = 1'b1;
    q0.push_back(model(sA, 32'hE000_0000, 1));
    q0.push_back(model(sA, 32'hE000_0000, 2));
    q2.push_back(model(sA, 32'hE000_0000, 17));
    pulse_start(); t0 = cyc;
    chk("busy_after_start", 32'(b0), 1);
    wait_v(0, 40, n);
    chk("lat_first", 32'(n), 11);
    chk_s("basic1", r0, q0.pop_front());
    chk("basic1_const", r0[2], 32'hE000_0000);
    chk("maxr_vld", 32'(v1), 1);
    chk_s("maxr", r1, ones);
    step();
    chk("vld_drop", 32'(v0), 0);
    wait_v(0, 40, n);
    chk("lat_next", 32'(n), 11);
    chk_s("basic2", r0, q0.pop_front());
    chk("basic2_const", r0[4], 32'h6200_0000);
    wait_v(2, 300, n);
    chk("warm_lat", 32'(cyc - t0), 171);
    chk_s("warm", r2, q2.pop_front());

    // stop returns all instances to idle
    pulse_stop();
    chk("stop_busy", 32'(b0), 0);
    chk("stop_vld", 32'(v0), 0);
    chk("stop_busy2", 32'(b2), 0);

    // backpressure
    rdy = 1'b0;
    q0.push_back(model(sA, 32'hE000_0000, 1));
    q0.push_back(model(sA, 32'hE000_0000, 2));
    pulse_start();
    wait_v(0, 40, n);
    chk("bp_lat", 32'(n), 11);
    chk_s("bp1", r0, q0.pop_front());
    held = r0; bad = 0;
    repeat (50) begin
      step();
      if (v0 !== 1'b1 || r0 !== held) bad++;
    end
    chk("bp_hold", 32'(bad), 0);
    rdy = 1'b1; step(); rdy = 1'b0;
    chk("bp_drop", 32'(v0), 0);
    lows = 0;
    repeat (10) begin step(); if (v0 === 1'b0) lows++; end
    chk("bp_gap", 32'(lows), 10);
    step();
    chk("bp_rise", 32'(v0), 1);
    chk_s("bp2", r0, q0.pop_front());

    // zero-seed guard
    pulse_stop();
    seed = sZ;
    q0.push_back(model(sZ, 32'hE000_0000, 1));
    pulse_start();
    wait_v(0, 40, n);
    chk("zs_lat", 32'(n), 11);
    chk_s("zs", r0, q0.pop_front());
    chk("zs_x1", r0[0], 32'h0000_0001);

    // stop mid-calculation: outputs hold, then restart reproduces from seed
    prev = r0;
    pulse_stop();
    seed = sR;
    pulse_start();
    repeat (4) step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("abort_busy", 32'(b0), 0);
    chk("abort_vld", 32'(v0), 0);
    chk_s("abort_hold", r0, prev);

    // restart, with start pulses while busy that must be ignored
    q0.push_back(model(sR, 32'hE000_0000, 1));
    q0.push_back(model(sR, 32'hE000_0000, 2));
    pulse_start(); t0 = cyc;
    repeat (2) step();
    seed = sA; pulse_start(); seed = sR;
    wait_v(0, 40, n);
    chk("rs_lat", 32'(cyc - t0), 11);
    chk_s("rs1", r0, q0.pop_front());
    rdy = 1'b1; step(); rdy = 1'b0;
    repeat (3) step();
    seed = sA; pulse_start(); seed = sR;
    wait_v(0, 40, n);
    chk_s("rs2", r0, q0.pop_front());

    // start coincident with stop in idle stays idle
    pulse_stop();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("ss_busy", 32'(b0), 0);
    repeat (12) step();
    chk("ss_vld", 32'(v0), 0);

    // asynchronous reset while in OUT
    seed = sA;
    pulse_start();
    wait_v(0, 40, n);
    chk("pre_rst_vld", 32'(v0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_s("arst_data", r0, '0);
    chk("arst_vld", 32'(v0), 0);
    chk("arst_busy", 32'(b0), 0);
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
